// File: rtl/ctrl_sequencer_if.sv
// Control-word link between the sequencer (master) and the processing unit (slave).
// ctrl_word is valid every cycle with no backpressure; state_flags are the datapath's registered flags.
interface ctrl_sequencer_if;
  logic [15:0] ctrl_word;
  logic [3:0]  state_flags;

  modport master (output ctrl_word, input state_flags);
  modport slave  (input ctrl_word, output state_flags);
endinterface

// File: rtl/ctrl_sequencer.sv
// Microprogrammed sequencer issuing one 16-bit control word per cycle from a writable store.
// Optional single-step input guarded by macro SEQ_STEP_EN.
module ctrl_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              start,
  ctrl_sequencer_if.master  cif,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [19:0]       prog_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [19:0] mem [DEPTH];
  logic [19:0] instr;
  logic        last_exec;
  logic        adv;
  logic        taken;

`ifdef SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign instr = mem[pc];
  assign taken = (cif.state_flags[instr[17:16]] == instr[15]);

  // Store is not reset; writes are accepted only while idle.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  end

  // busy is a registered copy of the state bit and serves as the FSM debug view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= '0;
      cif.ctrl_word <= 16'h0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      last_exec     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cif.ctrl_word <= 16'h0000;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            pc        <= '0;
            last_exec <= 1'b0;
          end
        end
        RUN: begin
          cif.ctrl_word <= 16'h0000;
          if (adv) begin
            case (instr[19:18])
              2'b00: begin
                cif.ctrl_word <= instr[15:0];
                pc            <= pc + ADDR_W'(1);
                last_exec     <= 1'b1;
              end
              2'b01: begin
                pc        <= instr[ADDR_W-1:0];
                last_exec <= 1'b0;
              end
              2'b10: begin
                // After an EXEC, hold one cycle so its flags reach state_flags.
                last_exec <= 1'b0;
                if (!last_exec) pc <= taken ? instr[ADDR_W-1:0] : pc + ADDR_W'(1);
              end
              default: begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                last_exec <= 1'b0;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Microprogrammed control unit that drives the 16-bit control word {A[2:0],B[2:0],D[2:0],F[3:0],H[2:0]} into the processing unit. It runs a small writable micro-program store and issues one control word per cycle. It branches conditionally on the processing unit's registered 4-bit STATE_flags. It is the initiator end of the control-word interface the datapath consumes.

Parameters:
DEPTH, 16, micro-program words; must be a power of two, >=4
ADDR_W, $clog2(DEPTH), program-counter and jump-target width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; starts execution at address 0 when IDLE
state_flags  input  4  registered flags from the processing unit
prog_we  input  1  micro-program write strobe
prog_addr  input  ADDR_W  write address
prog_data  input  20  micro-instruction to write
ctrl_word  output  16  registered control word to the processing unit
pc  output  ADDR_W  current program counter
busy  output  1  high in RUN
done  output  1  one-cycle pulse on HALT

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Micro-instruction format:
  - [19:18] op: 00 EXEC, 01 JMP, 10 BR, 11 HALT.
  - EXEC: [15:0] = control word.
  - JMP: [ADDR_W-1:0] = target.
  - BR: [17:16] = flag index, [15] = polarity (branch taken when state_flags[idx]==polarity), [ADDR_W-1:0] = target.
- Store: DEPTH x 20 registers, not reset. A write occurs on a clk edge with prog_we=1 only in IDLE. Writes in RUN are ignored.
- Reset: state=IDLE, pc=0, ctrl_word=16'h0000, busy=0, done=0, last_exec=0. Reset mid-run aborts immediately with no done pulse.
- NOP: ctrl_word=0, meaning A=B=D=0, so no register write.
- FSM states: IDLE, RUN.
- IDLE:
  - ctrl_word=0.
  - start=1 -> RUN, pc=0, last_exec=0.
  - start while RUN is ignored.
- RUN, each cycle decodes mem[pc]:
  - EXEC: ctrl_word<=word; pc<=pc+1 (wraps DEPTH-1 -> 0); last_exec<=1.
  - JMP: ctrl_word<=0; pc<=target; last_exec<=0.
  - BR with last_exec=1 (hazard stall): pc holds; ctrl_word<=0; last_exec<=0. This one-cycle bubble lets the datapath latch flags of the preceding EXEC.
  - BR with last_exec=0: ctrl_word<=0; pc<=taken ? target : pc+1 (wrapping).
  - HALT: ctrl_word<=0; pc holds; -> IDLE; done=1 for exactly the next cycle.
- Latency: an EXEC decoded in cycle n appears on ctrl_word in cycle n+1, and its flags are visible on state_flags from cycle n+2.
- Flag semantics: a BR always tests the flags of the most recently issued word. After a JMP or BR, that word is the NOP.
- busy=1 exactly while state=RUN. done and busy are never high together.
- Simultaneous start and prog_we in IDLE: the write completes and RUN begins; the write is visible at its address.
- Infinite loops (JMP to self) are legal and run until rst.

Optional Feature:
Macro SEQ_STEP_EN adds input step (1 bit).
- Enabled: in RUN, decode/advance happens only on cycles with step=1. Without step, ctrl_word=0, pc holds, and last_exec is unchanged. The hazard stall also consumes a step.
- Disabled: the port is absent and the sequencer advances every cycle.

Test Plan:
1. Program {EXEC 16'h2488, EXEC 16'h4A10, HALT}, pulse start -> ctrl_word 2488, 4A10, 0000 on consecutive cycles; done one cycle; busy 3 cycles.
2. EXEC at 0, BR idx=2 pol=1 target=5 at 1, state_flags=4'b0100 driven from the EXEC cycle -> one stall cycle with pc=1, then pc=5.
3. Same program with state_flags=4'b0000 -> pc goes 1 -> 2 (not taken) after the stall.
4. JMP 0 at address DEPTH-1; EXEC at all other addresses -> pc sequence 0..DEPTH-2, DEPTH-1, 0; ctrl_word=0 in the JMP cycle.
5. Assert rst asynchronously (between edges) mid-run -> ctrl_word=0, pc=0, busy=0 immediately; no done pulse; a prog_we write issued during RUN is not stored.
6. (SEQ_STEP_EN) step held low 5 cycles in RUN -> pc constant, ctrl_word=0; one step pulse -> exactly one instruction issued.
